ring_counter_16_bit_monitor: RTL and testbench

Read-side checker for the 16-bit ring counter. It samples the counter's one-hot value and running flag, and decodes the hot bit to a binary position. It verifies that each change is a legal single-step left rotation, and counts full revolutions. It sits beside the counter on the board/bench and flags corrupted or illegal counter behaviour in-system.

---
 rtl/ring_counter_16_bit_monitor.sv | 118 +++++++++++
 tb/tb_ring_counter_16_bit_monitor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter_16_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : ring_counter_16_bit_monitor
// Description : Read-side checker for a one-hot ring counter. Decodes the hot
//               bit, validates single-step left rotations and counts laps.
// Revision    : 1.0 - initial release
// ============================================================================
module ring_counter_16_bit_monitor #(
  parameter int WIDTH         = 16,
  parameter int REV_CNT_WIDTH = 16,
  localparam int POS_WIDTH    = $clog2(WIDTH)
) (
  input  logic                     Clk_In,
  input  logic                     Reset_In,
  input  logic                     Enable_In,
  input  logic                     Clear_Command_In,
  input  logic                     Counter_Running_Flag_In,
  input  logic [WIDTH-1:0]         Counter_Count_In,
  output logic [POS_WIDTH-1:0]     Position_Out,
  output logic                     Position_Valid_Out,
  output logic                     Step_Out,
  output logic [REV_CNT_WIDTH-1:0] Revolution_Count_Out,
  output logic                     Onehot_Error_Flag_Out,
  output logic                     Sequence_Error_Flag_Out,
  output logic [7:0]               Error_Count_Out
);

  localparam logic [7:0] c_ERR_MAX = 8'hFF;

  logic [WIDTH-1:0]         r_sample;
  logic [WIDTH-1:0]         r_prev;
  logic                     r_run;
  logic                     r_run_prev;
  logic                     r_primed;
  logic [POS_WIDTH-1:0]     r_position;
  logic                     r_valid;
  logic                     r_step;
  logic [REV_CNT_WIDTH-1:0] r_rev_count;
  logic                     r_onehot_err;
  logic                     r_seq_err;
  logic [7:0]               r_err_count;

  logic                     w_onehot;
  logic [POS_WIDTH-1:0]     w_index;
  logic [WIDTH-1:0]         w_rotl;
  logic                     w_moved;
  logic                     w_legal_move;
  logic                     w_step;
  logic                     w_seq_err;
  logic                     w_onehot_err;
  logic                     w_err_event;

  assign w_onehot     = (r_sample != '0) && ((r_sample & (r_sample - WIDTH'(1))) == '0);
  assign w_rotl       = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
  assign w_moved      = (r_sample != r_prev);
  // The running flag leads the value by one sample, so legality keys off RP.
  assign w_legal_move = (r_sample == w_rotl) && r_run_prev;
  assign w_step       = w_onehot && r_primed && w_moved && w_legal_move;
  assign w_seq_err    = w_onehot && r_primed && w_moved && !w_legal_move;
  assign w_onehot_err = !w_onehot;
  assign w_err_event  = w_onehot_err || w_seq_err;

  always_comb begin
    w_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (r_sample[i]) w_index = i[POS_WIDTH-1:0];
    end
  end

  always_ff @(posedge Clk_In or negedge Reset_In) begin
    if (!Reset_In) begin
      r_sample     <= WIDTH'(1);
      r_prev       <= WIDTH'(1);
      r_run        <= 1'b0;
      r_run_prev   <= 1'b0;
      r_primed     <= 1'b0;
      r_position   <= '0;
      r_valid      <= 1'b0;
      r_step       <= 1'b0;
      r_rev_count  <= '0;
      r_onehot_err <= 1'b0;
      r_seq_err    <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_sample   <= Counter_Count_In;
      r_run      <= Counter_Running_Flag_In;
      r_prev     <= r_sample;
      r_run_prev <= r_run;
      r_step     <= w_step;
      r_valid    <= w_onehot;
      if (w_onehot) r_position <= w_index;

      if (Clear_Command_In) begin
        r_primed     <= 1'b0;
        r_rev_count  <= '0;
        r_onehot_err <= 1'b0;
        r_seq_err    <= 1'b0;
        r_err_count  <= '0;
      end else begin
        r_primed <= w_onehot;
        if (w_onehot_err) r_onehot_err <= 1'b1;
        if (w_seq_err)    r_seq_err    <= 1'b1;
        if (w_step && r_prev[WIDTH-1]) r_rev_count <= r_rev_count + REV_CNT_WIDTH'(1);
        if (w_err_event && (r_err_count != c_ERR_MAX)) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

  assign Position_Out            = Enable_In ? r_position   : {POS_WIDTH{1'bz}};
  assign Position_Valid_Out      = Enable_In ? r_valid      : 1'bz;
  assign Step_Out                = Enable_In ? r_step       : 1'bz;
  assign Revolution_Count_Out    = Enable_In ? r_rev_count  : {REV_CNT_WIDTH{1'bz}};
  assign Onehot_Error_Flag_Out   = Enable_In ? r_onehot_err : 1'bz;
  assign Sequence_Error_Flag_Out = Enable_In ? r_seq_err    : 1'bz;
  assign Error_Count_Out         = Enable_In ? r_err_count  : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_ring_counter_16_bit_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_ring_counter_16_bit_monitor
// Description : Randomized bench for ring_counter_16_bit_monitor against a
//               position-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ring_counter_16_bit_monitor;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic          clr = 1'b0;
  logic          run = 1'b0;
  logic [W-1:0]  cnt = 16'h0001;

  wire [3:0]     pos;
  wire           valid;
  wire           step;
  wire [15:0]    rev;
  wire           oh_flag;
  wire           seq_flag;
  wire [7:0]     err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [W-1:0] m_s, m_p;
  bit           m_r, m_rp, m_primed, m_valid, m_step, m_oh, m_seq;
  int           m_pos, m_rev, m_ec;

  ring_counter_16_bit_monitor #(.WIDTH(16), .REV_CNT_WIDTH(16)) dut (
    .Clk_In                  (clk),
    .Reset_In                (rst_n),
    .Enable_In               (en),
    .Clear_Command_In        (clr),
    .Counter_Running_Flag_In (run),
    .Counter_Count_In        (cnt),
    .Position_Out            (pos),
    .Position_Valid_Out      (valid),
    .Step_Out                (step),
    .Revolution_Count_Out    (rev),
    .Onehot_Error_Flag_Out   (oh_flag),
    .Sequence_Error_Flag_Out (seq_flag),
    .Error_Count_Out         (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int idx(input logic [W-1:0] v);
    for (int i = 0; i < W; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x);
    return {x[W-2:0], x[W-1]};
  endfunction

  task automatic model_reset();
    m_s = 16'h0001; m_p = 16'h0001; m_r = 0; m_rp = 0; m_primed = 0;
    m_pos = 0; m_valid = 0; m_step = 0; m_rev = 0; m_oh = 0; m_seq = 0; m_ec = 0;
  endtask

  // One rising edge of the checker, expressed in hot-bit positions.
  task automatic model_edge();
    bit ohe, se, nprimed;
    ohe = 0; se = 0; nprimed = 0; m_step = 0;
    if ($countones(m_s) != 1) begin
      ohe = 1; m_valid = 0;
    end else begin
      m_pos = idx(m_s); m_valid = 1; nprimed = 1;
      if (m_primed && idx(m_s) != idx(m_p)) begin
        if (idx(m_s) == (idx(m_p) + 1) % W && m_rp) begin
          m_step = 1;
          if (idx(m_p) == W - 1) m_rev = (m_rev + 1) % 65536;
        end else begin
          se = 1;
        end
      end
    end
    if (clr) begin
      m_oh = 0; m_seq = 0; m_ec = 0; m_rev = 0; m_primed = 0;
    end else begin
      m_primed = nprimed;
      if (ohe) m_oh = 1;
      if (se) m_seq = 1;
      if ((ohe || se) && m_ec < 255) m_ec++;
    end
    m_p = m_s; m_rp = m_r; m_s = cnt; m_r = run;
  endtask

  task automatic check_outputs();
    check("position", 32'(pos), 32'(m_pos));
    check("valid", 32'(valid), 32'(m_valid));
    check("step", 32'(step), 32'(m_step));
    check("revolutions", 32'(rev), 32'(m_rev));
    check("onehot_flag", 32'(oh_flag), 32'(m_oh));
    check("seq_flag", 32'(seq_flag), 32'(m_seq));
    check("err_count", 32'(err_cnt), 32'(m_ec));
  endtask

  // Released outputs read as Z (4-state) or 0 (2-state); a driven 1 anywhere is wrong.
  task automatic check_hiz();
    logic [31:0] bus;
    bus = {pos, valid, step, rev, oh_flag, seq_flag, err_cnt};
    check("hiz", 32'((|bus) !== 1'b1), 32'd1);
  endtask

  task automatic cyc(input logic [W-1:0] c, input bit r, input bit cl);
    cnt = c; run = r; clr = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (en) check_outputs();
    else check_hiz();
  endtask

  initial begin
    logic [W-1:0] v;
    bit r, cl;
    int k;

    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) cyc(16'h0001, 0, 0);

    v = 16'h0001;
    cyc(v, 1, 0);
    for (int i = 0; i < 20; i++) begin
      v = rotl(v);
      cyc(v, 1, 0);
    end
    v = rotl(v);
    cyc(v, 0, 0);
    cyc(v, 0, 0);

    cyc(16'h0003, 0, 0);
    cyc(16'h0004, 0, 0);
    cyc(16'h0004, 0, 0);
    cyc(16'h0004, 0, 0);

    cyc(16'h0001, 1, 0);
    cyc(16'h0001, 1, 0);
    cyc(16'h0004, 1, 0);
    cyc(16'h0004, 1, 0);
    cyc(16'h0010, 0, 0);
    cyc(16'h0010, 0, 0);
    cyc(16'h0020, 1, 0);
    cyc(16'h0020, 1, 0);

    cyc(16'h0001, 1, 0);
    cyc(16'h0100, 1, 0);
    cyc(16'h0100, 1, 1);
    cyc(16'h0100, 1, 0);
    for (int i = 0; i < 300; i++) cyc(16'h0000, 1, 0);
    cyc(16'h0001, 0, 0);
    cyc(16'h0001, 0, 1);
    cyc(16'h0001, 0, 0);

    v = 16'h0001; r = 1;
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 99);
      if (k < 65)      v = r ? rotl(v) : v;
      else if (k < 80) v = v;
      else if (k < 88) v = 16'h0001 << $urandom_range(0, 15);
      else if (k < 95) v = 16'($urandom);
      else             v = 16'h0000;
      if ($urandom_range(0, 9) == 0) r = ~r;
      cl = ($urandom_range(0, 39) == 0);
      cyc(v, r, cl);
    end

    v = 16'h0001;
    cyc(v, 1, 0);
    cyc(v, 1, 0);
    for (int i = 0; i < 6; i++) begin
      v = rotl(v);
      cyc(v, 1, 0);
    end
    en = 1'b0;
    #1 check_hiz();
    for (int i = 0; i < 36; i++) begin
      v = rotl(v);
      cyc(v, 1, 0);
    end
    en = 1'b1;
    #1 check_outputs();
    for (int i = 0; i < 4; i++) begin
      v = rotl(v);
      cyc(v, 1, 0);
    end

    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    v = rotl(v);
    for (int i = 0; i < 6; i++) begin
      cyc(v, 1, 0);
      v = rotl(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
